// File: rtl/seg7_scan_driver_if.sv
// Bus between a value source and the 8-digit scan driver: the displayed word,
// its load strobe, per-digit controls and the active-low display pins.
interface seg7_scan_driver_if;
   logic [31:0] value;
   logic        load;
   logic [7:0]  digit_en;
   logic [7:0]  dp;
   logic [6:0]  segments;
   logic        dp_n;
   logic [7:0]  anodos;

   modport master (
      output value, load, digit_en, dp,
      input  segments, dp_n, anodos
   );

   modport slave (
      input  value, load, digit_en, dp,
      output segments, dp_n, anodos
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// A shadow register decouples the displayed word from the live input, each
// digit slot begins with an all-off guard interval to stop ghosting, and
// leading zero digits can be suppressed. All pins are registered.
module seg7_scan_driver #(
   parameter int unsigned REFRESH_DIV   = 100000,
   parameter int unsigned GUARD         = 4,
   parameter bit          BLANK_LEADING = 1'b1
) (
   input logic               clock,
   input logic               reset,
   seg7_scan_driver_if.slave bus
);

   localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] cnt_q,      cnt_d;
   logic [2:0]    idx_q,      idx_d;
   logic [31:0]   shadow_q,   shadow_d;
   logic [7:0]    anodos_q,   anodos_d;
   logic [6:0]    segments_q, segments_d;
   logic          dp_n_q,     dp_n_d;

   logic [7:0]    lz_s;
   logic [3:0]    nib_s;
   logic          guard_s;
   logic          blank_s;

   // Active-low {CA..CG} pattern for one hex nibble.
   function automatic logic [6:0] decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b0000001;
         4'h1:    seg = 7'b1001111;
         4'h2:    seg = 7'b0010010;
         4'h3:    seg = 7'b0000110;
         4'h4:    seg = 7'b1001100;
         4'h5:    seg = 7'b0100100;
         4'h6:    seg = 7'b0100000;
         4'h7:    seg = 7'b0001111;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0000100;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b1100000;
         4'hC:    seg = 7'b0110001;
         4'hD:    seg = 7'b1000010;
         4'hE:    seg = 7'b0110000;
         4'hF:    seg = 7'b0111000;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   // Next-state for prescaler, digit index, shadow and the display pins,
   // all derived from the current (pre-edge) register values.
   always_comb begin
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shadow_d   = shadow_q;
      anodos_d   = 8'hFF;
      segments_d = 7'h7F;
      dp_n_d     = 1'b1;

      // Slot advance: the index only moves when the prescaler wraps.
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = idx_q + 3'd1;
      end else begin
         cnt_d = cnt_q + CW'(1);
         idx_d = idx_q;
      end

      if (bus.load) begin
         shadow_d = bus.value;
      end else begin
         shadow_d = shadow_q;
      end

      // lz_s[i]: nibbles i..7 of the shadow are all zero.
      for (int i = 0; i < 8; i++) begin
         lz_s[i] = ((shadow_q >> (4 * i)) == 32'd0);
      end

      nib_s   = shadow_q[{idx_q, 2'b00} +: 4];
      guard_s = (32'(cnt_q) < GUARD);
      blank_s = !bus.digit_en[idx_q] ||
                (BLANK_LEADING && (idx_q != 3'd0) && lz_s[idx_q]);

      if (guard_s || blank_s) begin
         anodos_d   = 8'hFF;
         segments_d = 7'h7F;
         dp_n_d     = 1'b1;
      end else begin
         anodos_d   = ~(8'd1 << idx_q);
         segments_d = decode(nib_s);
         dp_n_d     = ~bus.dp[idx_q];
      end
   end

   // State and output registers with synchronous reset to a dark display.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q      <= '0;
         idx_q      <= 3'd0;
         shadow_q   <= 32'd0;
         anodos_q   <= 8'hFF;
         segments_q <= 7'h7F;
         dp_n_q     <= 1'b1;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shadow_q   <= shadow_d;
         anodos_q   <= anodos_d;
         segments_q <= segments_d;
         dp_n_q     <= dp_n_d;
      end
   end

   assign bus.anodos   = anodos_q;
   assign bus.segments = segments_q;
   assign bus.dp_n     = dp_n_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (leading-zero blanking on and off)
// share stimulus; a time-based model predicts every output each cycle, and
// directed literal checks pin the model at hand-computed points.
module tb_seg7_scan_driver;

   localparam int RD = 8;
   localparam int GD = 2;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dpn;
   } disp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] value_s = 32'd0;
   logic        load_s = 1'b0;
   logic [7:0]  en_s = 8'hFF;
   logic [7:0]  dp_s = 8'h00;

   int n_checks = 0;
   int n_errors = 0;
   int cur_k = 0;

   seg7_scan_driver_if if0 ();
   seg7_scan_driver_if if1 ();

   assign if0.value = value_s;  assign if1.value = value_s;
   assign if0.load = load_s;    assign if1.load = load_s;
   assign if0.digit_en = en_s;  assign if1.digit_en = en_s;
   assign if0.dp = dp_s;        assign if1.dp = dp_s;

   seg7_scan_driver #(.REFRESH_DIV(RD), .GUARD(GD), .BLANK_LEADING(1'b1)) dut0 (
      .clock(clock), .reset(reset), .bus(if0.slave));
   seg7_scan_driver #(.REFRESH_DIV(RD), .GUARD(GD), .BLANK_LEADING(1'b0)) dut1 (
      .clock(clock), .reset(reset), .bus(if1.slave));

   always #5 clock = ~clock;

   function automatic logic [6:0] seg_of(input int n);
      case (n)
         0: return 7'b0000001;   1: return 7'b1001111;
         2: return 7'b0010010;   3: return 7'b0000110;
         4: return 7'b1001100;   5: return 7'b0100100;
         6: return 7'b0100000;   7: return 7'b0001111;
         8: return 7'b0000000;   9: return 7'b0000100;
         10: return 7'b0001000;  11: return 7'b1100000;
         12: return 7'b0110001;  13: return 7'b1000010;
         14: return 7'b0110000;  default: return 7'b0111000;
      endcase
   endfunction

   // Display for the cycle t cycles after reset, given shadow and controls.
   function automatic disp_t model(input bit bl, input int t, input logic [31:0] sh,
                                   input logic [7:0] en, input logic [7:0] dp);
      disp_t d;
      int cnt, idx, nib;
      bit blank;
      cnt = t % RD;
      idx = (t / RD) % 8;
      nib = int'((sh >> (4 * idx)) & 32'hF);
      blank = (en[idx] == 1'b0) || (bl && idx != 0 && (sh >> (4 * idx)) == 32'd0);
      if (cnt < GD || blank) begin
         d.an = 8'hFF; d.seg = 7'h7F; d.dpn = 1'b1;
      end else begin
         d.an = 8'hFF ^ (8'd1 << idx);
         d.seg = seg_of(nib);
         d.dpn = ~dp[idx];
      end
      return d;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: cycles since reset and the shadow word.
   int          t_m = 0;
   logic [31:0] sh_m = 32'd0;
   disp_t       exp0, exp1;
   bit          valid_m = 1'b0;

   // Predict registered outputs from the pre-edge model state.
   always @(posedge clock) begin
      valid_m <= 1'b1;
      if (reset) begin
         t_m  <= 0;
         sh_m <= 32'd0;
         exp0 <= '{8'hFF, 7'h7F, 1'b1};
         exp1 <= '{8'hFF, 7'h7F, 1'b1};
      end else begin
         exp0 <= model(1'b1, t_m, sh_m, en_s, dp_s);
         exp1 <= model(1'b0, t_m, sh_m, en_s, dp_s);
         t_m  <= t_m + 1;
         if (load_s) sh_m <= value_s;
      end
   end

   // Per-cycle comparison of both instances against the model plus invariants.
   always @(negedge clock) begin
      if (valid_m) begin
         cmp("m0_an", 32'(if0.anodos), 32'(exp0.an));
         cmp("m0_seg", 32'(if0.segments), 32'(exp0.seg));
         cmp("m0_dp", 32'(if0.dp_n), 32'(exp0.dpn));
         cmp("m1_an", 32'(if1.anodos), 32'(exp1.an));
         cmp("m1_seg", 32'(if1.segments), 32'(exp1.seg));
         cmp("m1_dp", 32'(if1.dp_n), 32'(exp1.dpn));
         cmp("onehot0", 32'($countones(~if0.anodos) <= 1), 32'd1);
         cmp("dark_seg0", 32'(if0.anodos != 8'hFF || if0.segments == 7'h7F), 32'd1);
      end
   end

   task automatic wait_edge(input int k);
      while (cur_k < k) begin
         @(negedge clock);
         cur_k++;
      end
   endtask

   // Reset for three cycles, then release with a load of v.
   task automatic restart(input logic [31:0] v, input logic [7:0] en, input logic [7:0] dp);
      @(negedge clock);
      reset = 1'b1;
      load_s = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      load_s = 1'b1;
      value_s = v;
      en_s = en;
      dp_s = dp;
      cur_k = 0;
      wait_edge(1);
      load_s = 1'b0;
   endtask

   initial begin
      // Reset state.
      repeat (3) @(negedge clock);
      cmp("rst_an", 32'(if0.anodos), 32'hFF);
      cmp("rst_seg", 32'(if0.segments), 32'h7F);
      cmp("rst_dp", 32'(if0.dp_n), 32'd1);

      // A5 with leading-zero blanking.
      restart(32'h0000_00A5, 8'hFF, 8'h00);
      wait_edge(2);
      cmp("a5_guard", 32'(if0.anodos), 32'hFF);
      wait_edge(3);
      cmp("a5_d0_an", 32'(if0.anodos), 32'hFE);
      cmp("a5_d0_seg", 32'(if0.segments), 32'(7'b0100100));
      wait_edge(11);
      cmp("a5_d1_an", 32'(if0.anodos), 32'hFD);
      cmp("a5_d1_seg", 32'(if0.segments), 32'(7'b0001000));
      wait_edge(19);
      cmp("a5_d2_blank", 32'(if0.anodos), 32'hFF);
      cmp("a5_d2_noblank_an", 32'(if1.anodos), 32'hFB);
      cmp("a5_d2_noblank_seg", 32'(if1.segments), 32'(7'b0000001));
      wait_edge(70);

      // Full digit sweep without blanking.
      restart(32'h1234_5678, 8'hFF, 8'h00);
      wait_edge(3);
      cmp("sw_d0_seg", 32'(if1.segments), 32'(7'b0000000));
      wait_edge(11);
      cmp("sw_d1_seg", 32'(if1.segments), 32'(7'b0001111));
      wait_edge(59);
      cmp("sw_d7_an", 32'(if1.anodos), 32'h7F);
      cmp("sw_d7_seg", 32'(if1.segments), 32'(7'b1001111));
      wait_edge(66);

      // Zero value with decimal point on digit 0.
      restart(32'h0000_0000, 8'hFF, 8'h01);
      wait_edge(3);
      cmp("z_an", 32'(if0.anodos), 32'hFE);
      cmp("z_seg", 32'(if0.segments), 32'(7'b0000001));
      cmp("z_dp", 32'(if0.dp_n), 32'd0);
      wait_edge(11);
      cmp("z_d1_an", 32'(if0.anodos), 32'hFF);
      cmp("z_d1_dp", 32'(if0.dp_n), 32'd1);
      wait_edge(66);

      // Load coinciding with the wrap into digit 3.
      restart(32'h1111_1111, 8'hFF, 8'h00);
      wait_edge(23);
      load_s = 1'b1;
      value_s = 32'h2222_2222;
      wait_edge(24);
      load_s = 1'b0;
      cmp("wr_old_an", 32'(if0.anodos), 32'hFB);
      cmp("wr_old_seg", 32'(if0.segments), 32'(7'b1001111));
      wait_edge(27);
      cmp("wr_new_an", 32'(if0.anodos), 32'hF7);
      cmp("wr_new_seg", 32'(if0.segments), 32'(7'b0010010));
      wait_edge(40);

      // Disabled digit 2, then reset in the middle of digit 5.
      restart(32'h8888_8888, 8'hFB, 8'h00);
      wait_edge(11);
      cmp("en_d1_seg", 32'(if0.segments), 32'(7'b0000000));
      wait_edge(19);
      cmp("en_d2_an", 32'(if0.anodos), 32'hFF);
      cmp("en_d2_seg", 32'(if1.segments), 32'h7F);
      wait_edge(44);
      cmp("mid_d5_an", 32'(if0.anodos), 32'hDF);
      reset = 1'b1;
      wait_edge(45);
      cmp("mid_rst_an", 32'(if0.anodos), 32'hFF);
      cmp("mid_rst_seg", 32'(if0.segments), 32'h7F);
      cmp("mid_rst_dp", 32'(if0.dp_n), 32'd1);
      reset = 1'b0;
      cur_k = 0;
      wait_edge(3);
      cmp("resume_an", 32'(if0.anodos), 32'hFE);
      cmp("resume_seg", 32'(if0.segments), 32'(7'b0000001));
      wait_edge(20);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
